// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer. Entries are allocated at the tail by
// the dispatcher, marked ready by the RS/LSB CDBs, and retired one per cycle
// from the head. A control-flow mispredict at retirement flushes the window.
module rob_commit #(
    parameter int ROB_SIZE = 16,
    parameter int ID_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            enable_from_dsp,
    input  logic [1:0]      kind_from_dsp,
    input  logic [4:0]      rd_from_dsp,
    input  logic [31:0]     pc_from_dsp,
    input  logic [31:0]     pred_pc_from_dsp,
    output logic [ID_W-1:0] alloc_id,
    output logic            full_rob,
    input  logic            enable_cdb_rs,
    input  logic [ID_W-1:0] cdb_rs_rob_id,
    input  logic [31:0]     cdb_rs_value,
    input  logic [31:0]     cdb_rs_pc_next,
    input  logic            enable_cdb_lsb,
    input  logic [ID_W-1:0] cdb_lsb_rob_id,
    input  logic [31:0]     cdb_lsb_value,
    input  logic [ID_W-1:0] q1_id,
    input  logic [ID_W-1:0] q2_id,
    output logic            q1_ready,
    output logic            q2_ready,
    output logic [31:0]     q1_value,
    output logic [31:0]     q2_value,
    output logic            commit_en,
    output logic [4:0]      commit_rd,
    output logic [ID_W-1:0] commit_rob_id,
    output logic [31:0]     commit_value,
    output logic            store_commit,
    output logic [ID_W-1:0] store_commit_rob_id,
    output logic            mispredict,
    output logic [31:0]     pc_redirect
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam logic [1:0] K_REG = 2'd0, K_BR = 2'd1, K_ST = 2'd2, K_JMP = 2'd3;

    logic [ROB_SIZE-1:0] r_busy, r_ready;
    logic [1:0]          r_kind    [ROB_SIZE];
    logic [4:0]          r_rd      [ROB_SIZE];
    logic [31:0]         r_value   [ROB_SIZE];
    logic [31:0]         r_pc_next [ROB_SIZE];
    logic [31:0]         r_pred    [ROB_SIZE];
    logic [IDX_W-1:0]    r_head, r_tail;
    logic [IDX_W:0]      r_count;

    logic w_retire, w_mispred, w_alloc, w_is_ctl;
    logic [1:0] w_hkind;

    assign alloc_id = ID_W'(r_tail);
    assign full_rob = (r_count == (IDX_W+1)'(ROB_SIZE));

    // Retire/allocate decisions; retirement only sees registered ready so a
    // CDB write takes one edge before the entry can commit.
    always_comb begin
        w_hkind   = r_kind[r_head];
        w_retire  = rdy && r_busy[r_head] && r_ready[r_head];
        w_is_ctl  = (w_hkind == K_BR) || (w_hkind == K_JMP);
        w_mispred = w_retire && w_is_ctl && (r_pc_next[r_head] != r_pred[r_head]);
        // no allocation while a flush is being decided or is being signalled
        w_alloc   = rdy && enable_from_dsp && !full_rob && !mispredict && !w_mispred;
    end

    // Operand lookup: a same-cycle CDB hit bypasses the stored value.
    function automatic logic [32:0] f_lookup(input logic [ID_W-1:0] id);
        logic [IDX_W-1:0] ix;
        ix = id[IDX_W-1:0];
        f_lookup = '0;
        if (id < ID_W'(ROB_SIZE) && r_busy[ix]) begin
            if (enable_cdb_rs && cdb_rs_rob_id == id)        f_lookup = {1'b1, cdb_rs_value};
            else if (enable_cdb_lsb && cdb_lsb_rob_id == id) f_lookup = {1'b1, cdb_lsb_value};
            else if (r_ready[ix])                            f_lookup = {1'b1, r_value[ix]};
        end
    endfunction

    // Combinational dependency lookups for the dispatcher
    always_comb begin
        {q1_ready, q1_value} = f_lookup(q1_id);
        {q2_ready, q2_value} = f_lookup(q2_id);
    end

    // Entry storage: CDB capture, retirement free, tail allocation, flush
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy  <= '0;
            r_ready <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_kind[i]    <= K_REG;
                r_rd[i]      <= '0;
                r_value[i]   <= '0;
                r_pc_next[i] <= '0;
                r_pred[i]    <= '0;
            end
        end else if (rdy) begin
            if (w_mispred) begin
                r_busy <= '0;
            end else begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (r_busy[i] && enable_cdb_rs && cdb_rs_rob_id == ID_W'(i)) begin
                        r_ready[i]   <= 1'b1;
                        r_value[i]   <= cdb_rs_value;
                        r_pc_next[i] <= cdb_rs_pc_next;
                    end
                    if (r_busy[i] && enable_cdb_lsb && cdb_lsb_rob_id == ID_W'(i)) begin
                        r_ready[i] <= 1'b1;
                        r_value[i] <= cdb_lsb_value;
                    end
                end
                if (w_retire) r_busy[r_head] <= 1'b0;
                if (w_alloc) begin
                    r_busy[r_tail]    <= 1'b1;
                    r_ready[r_tail]   <= 1'b0;
                    r_kind[r_tail]    <= kind_from_dsp;
                    r_rd[r_tail]      <= rd_from_dsp;
                    r_pred[r_tail]    <= pred_pc_from_dsp;
                    // fall-through default until the RS reports the real target
                    r_pc_next[r_tail] <= pc_from_dsp + 32'd4;
                end
            end
        end
    end

    // Head/tail/count pointers; a flush empties the window in one edge
    always_ff @(posedge clk) begin
        if (!rst || (rdy && w_mispred)) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (w_retire) r_head <= r_head + 1'b1;
            if (w_alloc)  r_tail <= r_tail + 1'b1;
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered retirement outputs; pulses drop during a stall, data holds
    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_en           <= 1'b0;
            commit_rd           <= '0;
            commit_rob_id       <= '0;
            commit_value        <= '0;
            store_commit        <= 1'b0;
            store_commit_rob_id <= '0;
            mispredict          <= 1'b0;
            pc_redirect         <= '0;
        end else if (!rdy) begin
            commit_en    <= 1'b0;
            store_commit <= 1'b0;
            mispredict   <= 1'b0;
        end else begin
            commit_en    <= w_retire && (w_hkind == K_REG || w_hkind == K_JMP);
            store_commit <= w_retire && (w_hkind == K_ST);
            mispredict   <= w_mispred;
            if (w_retire && (w_hkind == K_REG || w_hkind == K_JMP)) begin
                commit_rd     <= r_rd[r_head];
                commit_rob_id <= ID_W'(r_head);
                commit_value  <= r_value[r_head];
            end
            if (w_retire && w_hkind == K_ST) store_commit_rob_id <= ID_W'(r_head);
            if (w_mispred) pc_redirect <= r_pc_next[r_head];
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: stimulus pushes expected retirements,
// a negedge monitor pops and compares every retirement pulse.
module tb_rob_commit;
    logic        clk = 0, rst = 0, rdy = 1;
    logic        enable_from_dsp = 0;
    logic [1:0]  kind_from_dsp = 0;
    logic [4:0]  rd_from_dsp = 0;
    logic [31:0] pc_from_dsp = 0, pred_pc_from_dsp = 0;
    logic [4:0]  alloc_id;
    logic        full_rob;
    logic        enable_cdb_rs = 0, enable_cdb_lsb = 0;
    logic [4:0]  cdb_rs_rob_id = 0, cdb_lsb_rob_id = 0;
    logic [31:0] cdb_rs_value = 0, cdb_rs_pc_next = 0, cdb_lsb_value = 0;
    logic [4:0]  q1_id = 5'h10, q2_id = 5'h10;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        commit_en, store_commit, mispredict;
    logic [4:0]  commit_rd, commit_rob_id, store_commit_rob_id;
    logic [31:0] commit_value, pc_redirect;

    rob_commit #(.ROB_SIZE(16), .ID_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .enable_from_dsp(enable_from_dsp), .kind_from_dsp(kind_from_dsp),
        .rd_from_dsp(rd_from_dsp), .pc_from_dsp(pc_from_dsp),
        .pred_pc_from_dsp(pred_pc_from_dsp), .alloc_id(alloc_id), .full_rob(full_rob),
        .enable_cdb_rs(enable_cdb_rs), .cdb_rs_rob_id(cdb_rs_rob_id),
        .cdb_rs_value(cdb_rs_value), .cdb_rs_pc_next(cdb_rs_pc_next),
        .enable_cdb_lsb(enable_cdb_lsb), .cdb_lsb_rob_id(cdb_lsb_rob_id),
        .cdb_lsb_value(cdb_lsb_value), .q1_id(q1_id), .q2_id(q2_id),
        .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_value(q1_value), .q2_value(q2_value),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
        .commit_value(commit_value), .store_commit(store_commit),
        .store_commit_rob_id(store_commit_rob_id), .mispredict(mispredict),
        .pc_redirect(pc_redirect)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 commit, 1 store, 2 mispredict
        logic [4:0]  rd;
        logic [4:0]  id;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [4:0] rd, input logic [4:0] id, input logic [31:0] v);
        exp_t e;
        e.kind = k; e.rd = rd; e.id = id; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic dispatch(input logic [1:0] k, input logic [4:0] rd,
                            input logic [31:0] pc, input logic [31:0] pred);
        enable_from_dsp = 1; kind_from_dsp = k; rd_from_dsp = rd;
        pc_from_dsp = pc; pred_pc_from_dsp = pred;
        tick();
        enable_from_dsp = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    // Monitor: every retirement pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst && commit_en) begin
            if (exp_q.size() == 0) chk("unexpected_commit", {27'd0, commit_rd}, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                chk("commit_kind", 32'd0, e.kind);
                chk("commit_rd", {27'd0, commit_rd}, {27'd0, e.rd});
                chk("commit_id", {27'd0, commit_rob_id}, {27'd0, e.id});
                chk("commit_value", commit_value, e.val);
            end
        end
        if (rst && store_commit) begin
            if (exp_q.size() == 0) chk("unexpected_store", {27'd0, store_commit_rob_id}, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                chk("store_kind", 32'd1, e.kind);
                chk("store_id", {27'd0, store_commit_rob_id}, {27'd0, e.id});
            end
        end
        if (rst && mispredict) begin
            if (exp_q.size() == 0) chk("unexpected_mispredict", pc_redirect, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                chk("mispredict_kind", 32'd2, e.kind);
                chk("pc_redirect", pc_redirect, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        do_reset();
        chk("rst_commit_en", {31'd0, commit_en}, 0);
        chk("rst_store", {31'd0, store_commit}, 0);
        chk("rst_mispredict", {31'd0, mispredict}, 0);
        chk("rst_pc_redirect", pc_redirect, 0);
        chk("rst_alloc_id", {27'd0, alloc_id}, 0);
        chk("rst_full", {31'd0, full_rob}, 0);

        // in-order commit of out-of-order completions
        for (int i = 0; i < 3; i++) begin
            chk("alloc_id_seq", {27'd0, alloc_id}, i);
            dispatch(2'd0, 5'(i + 1), 32'h0, 32'h4);
        end
        push(0, 5'd1, 5'd0, 32'h10);
        push(0, 5'd2, 5'd1, 32'h20);
        push(0, 5'd3, 5'd2, 32'h30);
        enable_cdb_rs = 1;
        cdb_rs_rob_id = 5'd2; cdb_rs_value = 32'h30; tick();
        cdb_rs_rob_id = 5'd0; cdb_rs_value = 32'h10; tick();
        cdb_rs_rob_id = 5'd1; cdb_rs_value = 32'h20; tick();
        enable_cdb_rs = 0;
        repeat (4) tick();

        // fill, overflow dispatch ignored, wrap after one retirement
        do_reset();
        for (int i = 0; i < 16; i++) dispatch(2'd0, 5'(i), 32'h0, 32'h4);
        chk("full_after_16", {31'd0, full_rob}, 1);
        chk("alloc_wrap_full", {27'd0, alloc_id}, 0);
        dispatch(2'd0, 5'd31, 32'h0, 32'h4);
        chk("full_after_17", {31'd0, full_rob}, 1);
        chk("alloc_17_ignored", {27'd0, alloc_id}, 0);
        push(0, 5'd0, 5'd0, 32'h55);
        enable_cdb_rs = 1; cdb_rs_rob_id = 5'd0; cdb_rs_value = 32'h55; tick();
        enable_cdb_rs = 0; tick();
        chk("full_after_retire", {31'd0, full_rob}, 0);
        chk("alloc_after_retire", {27'd0, alloc_id}, 0);
        dispatch(2'd0, 5'd4, 32'h0, 32'h4);
        chk("alloc_after_wrap", {27'd0, alloc_id}, 1);
        // reset mid-operation with a CDB in flight: no pulses afterwards
        rst = 0; enable_cdb_rs = 1; cdb_rs_rob_id = 5'd1; cdb_rs_value = 32'h99; tick();
        enable_cdb_rs = 0; tick();
        rst = 1;
        chk("midrst_full", {31'd0, full_rob}, 0);
        chk("midrst_alloc", {27'd0, alloc_id}, 0);
        repeat (3) tick();

        // branch mispredict flushes younger entries
        dispatch(2'd1, 5'd0, 32'h100, 32'h104);
        dispatch(2'd0, 5'd5, 32'h104, 32'h108);
        dispatch(2'd0, 5'd6, 32'h108, 32'h10C);
        enable_cdb_rs = 1; cdb_rs_rob_id = 5'd1; cdb_rs_value = 32'h77; cdb_rs_pc_next = 32'h108; tick();
        cdb_rs_rob_id = 5'd0; cdb_rs_value = 32'h0; cdb_rs_pc_next = 32'h200; tick();
        enable_cdb_rs = 0;
        push(2, 5'd0, 5'd0, 32'h200);
        enable_from_dsp = 1; kind_from_dsp = 2'd0; rd_from_dsp = 5'd7;
        tick();
        enable_from_dsp = 0;
        chk("mp_pulse", {31'd0, mispredict}, 1);
        chk("mp_redirect", pc_redirect, 32'h200);
        chk("mp_alloc_id", {27'd0, alloc_id}, 0);
        chk("mp_full", {31'd0, full_rob}, 0);
        q1_id = 5'd1; #1;
        chk("mp_flushed_lookup", {31'd0, q1_ready}, 0);
        tick();
        chk("mp_one_cycle", {31'd0, mispredict}, 0);
        repeat (3) tick();

        // JUMP with correct prediction commits rd, no redirect
        chk("jmp_alloc_id", {27'd0, alloc_id}, 0);
        dispatch(2'd3, 5'd1, 32'h40, 32'h80);
        push(0, 5'd1, 5'd0, 32'h44);
        enable_cdb_rs = 1; cdb_rs_rob_id = 5'd0; cdb_rs_value = 32'h44; cdb_rs_pc_next = 32'h80; tick();
        enable_cdb_rs = 0;
        repeat (3) tick();

        // lookup with same-cycle CDB bypass and NON_DEPENDENT
        dispatch(2'd0, 5'd11, 32'h0, 32'h4);
        dispatch(2'd0, 5'd12, 32'h0, 32'h4);
        dispatch(2'd0, 5'd13, 32'h0, 32'h4);
        q1_id = 5'd3; q2_id = 5'h10;
        enable_cdb_lsb = 1; cdb_lsb_rob_id = 5'd3; cdb_lsb_value = 32'hDEAD; #1;
        chk("q1_bypass_ready", {31'd0, q1_ready}, 1);
        chk("q1_bypass_value", q1_value, 32'hDEAD);
        chk("q2_nondep_ready", {31'd0, q2_ready}, 0);
        tick();
        enable_cdb_lsb = 0; q2_id = 5'd2; #1;
        chk("q1_stored_ready", {31'd0, q1_ready}, 1);
        chk("q1_stored_value", q1_value, 32'hDEAD);
        chk("q2_pending_ready", {31'd0, q2_ready}, 0);
        push(0, 5'd11, 5'd1, 32'h11);
        push(0, 5'd12, 5'd2, 32'h22);
        push(0, 5'd13, 5'd3, 32'hDEAD);
        enable_cdb_rs = 1; cdb_rs_rob_id = 5'd1; cdb_rs_value = 32'h11; cdb_rs_pc_next = 32'h4;
        enable_cdb_lsb = 1; cdb_lsb_rob_id = 5'd2; cdb_lsb_value = 32'h22;
        tick();
        enable_cdb_rs = 0; enable_cdb_lsb = 0;
        q1_id = 5'h10; q2_id = 5'h10;
        repeat (5) tick();

        // store commit, then a 3-cycle stall mid-stream
        dispatch(2'd2, 5'd0, 32'h0, 32'h4);
        dispatch(2'd0, 5'd9, 32'h0, 32'h4);
        dispatch(2'd0, 5'd10, 32'h0, 32'h4);
        push(1, 5'd0, 5'd4, 32'h0);
        push(0, 5'd9, 5'd5, 32'h55);
        push(0, 5'd10, 5'd6, 32'h66);
        enable_cdb_lsb = 1; cdb_lsb_rob_id = 5'd4; cdb_lsb_value = 32'h1000;
        enable_cdb_rs = 1; cdb_rs_rob_id = 5'd5; cdb_rs_value = 32'h55; cdb_rs_pc_next = 32'h4;
        tick();
        enable_cdb_lsb = 0; cdb_rs_rob_id = 5'd6; cdb_rs_value = 32'h66;
        tick();
        enable_cdb_rs = 0;
        rdy = 0; enable_from_dsp = 1; kind_from_dsp = 2'd0; rd_from_dsp = 5'd20;
        repeat (3) tick();
        chk("stall_alloc_hold", {27'd0, alloc_id}, 7);
        chk("stall_no_commit", {31'd0, commit_en}, 0);
        enable_from_dsp = 0; rdy = 1;
        repeat (5) tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer for the out-of-order core. It allocates an in-order entry for every instruction the dispatcher issues and absorbs result broadcasts from the RS and LSB CDBs. It retires at most one instruction per cycle from the head, driving the register file and the LSB store-commit path. On a control-flow mispredict at retirement it redirects fetch and flushes the whole window.

## Interface
- ROB_SIZE, 16, number of entries (power of two)
- ID_W, 5, ROB id width; ids 0..ROB_SIZE-1; value ROB_SIZE (5'b10000) is NON_DEPENDENT
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on posedge clk)
- rdy  in  1  global stall; when 0 no state changes, registered outputs hold
- enable_from_dsp  in  1  allocate one entry this cycle
- kind_from_dsp  in  2  0=REG (writes rd), 1=BRANCH, 2=STORE, 3=JUMP (writes rd and may redirect)
- rd_from_dsp  in  5  destination register
- pc_from_dsp  in  32  instruction pc
- pred_pc_from_dsp  in  32  predicted next pc
- alloc_id  out  ID_W  id the next allocation receives (= tail); combinational
- full_rob  out  1  count==ROB_SIZE; combinational
- enable_cdb_rs, cdb_rs_rob_id, cdb_rs_value, cdb_rs_pc_next  in  1/ID_W/32/32  RS broadcast
- enable_cdb_lsb, cdb_lsb_rob_id, cdb_lsb_value  in  1/ID_W/32  LSB broadcast (loads: value; stores: address ready)
- q1_id, q2_id  in  ID_W  dispatcher operand lookups
- q1_ready, q2_ready  out  1  entry result available (incl. same-cycle CDB hit); combinational
- q1_value, q2_value  out  32  the result
- commit_en  out  1  one-cycle pulse per retirement of REG/JUMP entries
- commit_rd, commit_rob_id, commit_value  out  5/ID_W/32  retirement data
- store_commit, store_commit_rob_id  out  1/ID_W  one-cycle pulse when a STORE retires
- mispredict  out  1  one-cycle flush pulse
- pc_redirect  out  32  correct next pc, valid with mispredict

## Operation
- Circular buffer: head, tail, count registers; head/tail wrap ROB_SIZE-1 -> 0.
- Allocation: if enable_from_dsp && !full_rob && !mispredict-in-progress, the entry at tail is written with busy=1, ready=0 and tail increments. Allocation while full is ignored (dispatcher contract violation, no state corruption).
- CDB capture: any busy entry whose id matches an enabled CDB is written with ready=1 and the value; from RS also the actual pc_next. Both CDBs may hit different ids in the same cycle; the same id on both is illegal.
- Retire: when the head entry is busy and ready, exactly one of these occurs:
  - REG: commit_en with rd, value and id. rd==0 is still committed; the regfile drops writes to x0.
  - STORE: store_commit with the id.
  - BRANCH / JUMP (JUMP also commits): if actual pc_next != pred_pc, also pulse mispredict with pc_redirect=actual pc_next.
- Retirement frees the head entry and increments head.
- Flush: in the cycle after a mispredict retire decision, the next-state logic clears all busy bits and sets head=tail=count=0. Allocation in the retiring cycle is dropped.
- count update: +1 on allocation, -1 on retire; both together leave it unchanged.
- Lookup: qN_ready = busy[id] && (ready[id] || same-cycle CDB hit on id). A CDB hit takes the CDB value. qN_id==NON_DEPENDENT gives ready=0.

## Timing
- Reset: head=tail=count=0, all busy=0, commit_en=store_commit=mispredict=0, commit_rd/rob_id/value, store_commit_rob_id and pc_redirect all 0.
- Outputs from reset are visible on the edge reset deasserts; full_rob=0, alloc_id=0.
- CDB-to-commit latency: CDB at edge N marks the entry ready; commit outputs are registered at edge N+1 if the entry is the head.
- Throughput: one retirement per cycle.
- The mispredict pulse lasts exactly one cycle. Downstream blocks flush on it. The ROB is empty in the same edge mispredict is registered, so alloc_id=0 the next cycle.
- Reset mid-operation discards all entries with no pulses.
- When rdy=0 nothing advances and pulses are not re-fired.

## Test plan
- Reset then 3 REG dispatches (rd 1,2,3) -> alloc_id 0,1,2. RS CDB on ids 2,0,1 with values 0x30,0x10,0x20 -> commits in order rd1=0x10, rd2=0x20, rd3=0x30 on consecutive cycles.
- Fill 16 entries -> full_rob=1 on the 16th edge; a 17th dispatch is ignored and alloc_id stays 0. Retire id 0 -> full_rob=0 and the next alloc is id 0 (wrap).
- BRANCH pc=0x100 pred=0x104, RS CDB pc_next=0x200 -> mispredict=1 and pc_redirect=0x200 for one cycle. Younger entries are never committed; count=0 afterwards.
- JUMP rd=1 pc=0x40 pred=0x80, CDB value 0x44 pc_next=0x80 -> commit_en rd1=0x44 with no mispredict.
- Lookup q1_id=3 while an LSB CDB broadcasts id 3 value 0xDEAD -> q1_ready=1, q1_value=0xDEAD in the same cycle.
- STORE at head, LSB CDB on its id -> store_commit=1 with the matching id. rdy=0 for 3 cycles mid-stream -> no pulses repeat and retirement resumes where it stopped.
